fifo_1r1w_flex: RTL and testbench
=================================

# fifo_1r1w_flex

Parametrised successor to the single-port-pair ready/valid FIFO, with these generalisations: arbitrary, non-power-of-two depth; occupancy count; programmable almost-full and almost-empty flags; and a synchronous flush. It sits between producer and consumer pipeline stages (fetch/decode/LSU queues) wherever elastic buffering needs back-pressure hints or squash-on-redirect. Storage is a register array and data_o is registered, so there is no RAM read latency to hide.

## Interface
- width_p, 8: data width in bits, ≥1.
- depth_p, 8: number of entries, any integer ≥2 (not restricted to powers of two).
- almost_full_p, depth_p-1: almost_full_o asserts when count_o ≥ this value; legal range 1..depth_p.
- almost_empty_p, 1: almost_empty_o asserts when count_o ≤ this value; legal range 0..depth_p-1.
- Derived count_w = $clog2(depth_p+1).

Ports:
- clk_i  in  1  single clock; all state updates on posedge.
- reset_i  in  1  reset, asynchronous and active-high.
- flush_i  in  1  synchronous clear of all contents.
- data_i  in  width_p  upstream data.
- valid_i  in  1  upstream valid.
- ready_o  out  1  upstream ready.
- valid_o  out  1  downstream valid (registered).
- data_o  out  width_p  downstream data (registered).
- ready_i  in  1  downstream ready.
- count_o  out  count_w  number of entries held, including the entry presented on data_o.
- almost_full_o  out  1  count_o ≥ almost_full_p.
- almost_empty_o  out  1  count_o ≤ almost_empty_p.

## Operation
- Push: push = valid_i & ready_o. Pop: pop = valid_o & ready_i.
- ready_o = ~full & ~flush_i & ~reset_i; full means count_o == depth_p.
- No pop-through-full: when full, ready_o stays 0 even if pop is high in the same cycle.
- Structure: an output register (data_o/valid_o) plus a backing array of depth_p-1 entries with head/tail pointers. Total capacity is exactly depth_p.
- Pointers wrap from depth_p-2 to 0 by explicit compare, not by bit truncation.
- Output register load rules:
  - Empty, or output register about to be vacated by a pop, with the array empty: load data_i directly (bypass) if push.
  - Array non-empty and output register empty or popping: load the array head and advance the head pointer.
  - Otherwise the output register holds its value.
- Push with no room in the output register: written to the array at the tail; tail advances.
- Next count = count + push − pop. A simultaneous push and pop leaves count unchanged.
- Flush (flush_i=1 at a clock edge):
  - head, tail and count go to 0; valid_o goes to 0.
  - pop in that cycle is ignored for state purposes; push is impossible because ready_o=0.
  - data_o holds its last value.
- Ordering is strict FIFO; no entry is duplicated or dropped except by flush or reset.
- almost_full_o and almost_empty_o are decoded from the registered count, so they have no combinational path from inputs.

## Timing
- Reset (async assert; release synchronous to clk_i by the system):
  - while reset_i=1: valid_o=0, data_o=0, count_o=0, ready_o=0, almost_full_o=0, almost_empty_o=1 (for almost_empty_p ≥ 0).
  - first cycle after release: ready_o=1.
- Reset asserted mid-operation clears everything immediately, independent of the clock. In-flight entries are lost.
- Latency: push into an empty FIFO gives valid_o=1 and data_o=data_i on the next cycle (1 cycle).
- Throughput: one push and one pop per cycle sustained, at any occupancy between 1 and depth_p-1.
- ready_o depends combinationally only on registered state, flush_i and reset_i, never on valid_i or ready_i.
- valid_o, data_o, count_o and the flags are pure register outputs.
- Holding rule: data_o and valid_o must remain stable while valid_o=1 and ready_i=0 (except under flush or reset).

## Test plan
All scenarios use width_p=8, depth_p=5, almost_full_p=4, almost_empty_p=1.

1. **Reset.**
   - Stimulus: assert reset_i mid-cycle while count_o=3.
   - Response: valid_o=0, count_o=0 and ready_o=0 immediately; ready_o=1 on the first edge after release.
2. **Fill and drain.**
   - Stimulus: ready_i=0, push 0x10..0x14.
   - Response: after the 5th push count_o=5, ready_o=0 and almost_full_o=1 (it first rose at count 4). Then with ready_i=1, pops return 0x10,0x11,0x12,0x13,0x14 on consecutive cycles, then valid_o=0 and count_o=0.
3. **Streaming with pointer wrap.**
   - Stimulus: valid_i=1 and ready_i=1 continuously with incrementing data 0x00..0x1F.
   - Response: data_o follows input with 1-cycle latency and no gaps; count_o stays at 1; the output sequence is exact.
4. **Random back-pressure.**
   - Stimulus: valid_i and ready_i each random 50%, 1000 items.
   - Response: a scoreboard sees in-order, lossless output; count_o always equals pushes − pops; data_o is stable whenever valid_o=1 and ready_i=0.
5. **Flush.**
   - Stimulus: fill to count 3, then assert flush_i for one cycle with valid_i=1 and ready_i=1.
   - Response: during the flush cycle ready_o=0. Next cycle count_o=0 and valid_o=0. A subsequent push of 0xAA appears as the first data_o.
6. **Full with simultaneous pop.**
   - Stimulus: at count 5, valid_i=1 and ready_i=1.
   - Response: the pop occurs and the push is not accepted (ready_o=0). count_o=4 next cycle, then ready_o=1.

Source files
------------

// File: rtl/fifo_1r1w_flex.sv
// Ready/valid FIFO with a registered output stage and a depth_p-1 entry backing array.
// Supports non-power-of-two depth, occupancy count, almost-full/empty flags and flush.
module fifo_1r1w_flex #(
   parameter int unsigned width_p        = 8,
   parameter int unsigned depth_p        = 8,
   parameter int unsigned almost_full_p  = depth_p - 1,
   parameter int unsigned almost_empty_p = 1,
   localparam int unsigned count_w       = $clog2(depth_p + 1)
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               flush_i,
   input  logic [width_p-1:0] data_i,
   input  logic               valid_i,
   output logic               ready_o,
   output logic               valid_o,
   output logic [width_p-1:0] data_o,
   input  logic               ready_i,
   output logic [count_w-1:0] count_o,
   output logic               almost_full_o,
   output logic               almost_empty_o
);

   localparam int unsigned arr_depth = depth_p - 1;
   localparam int unsigned ptr_w     = (arr_depth > 1) ? $clog2(arr_depth) : 1;

   logic [width_p-1:0] mem [0:arr_depth-1];

   logic [ptr_w-1:0]   head_r, head_n;
   logic [ptr_w-1:0]   tail_r, tail_n;
   logic [count_w-1:0] count_r, count_n;
   logic               valid_r, valid_n;
   logic [width_p-1:0] data_r, data_n;
   logic               af_r, af_n;
   logic               ae_r, ae_n;

   logic full;
   logic push;
   logic pop;
   logic out_free;
   logic arr_empty;
   logic wr_en;

   function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
      return (p == ptr_w'(depth_p - 2)) ? '0 : p + 1'b1;
   endfunction

   assign full      = (count_r == count_w'(depth_p));
   assign ready_o   = ~full & ~flush_i & ~reset_i;
   assign push      = valid_i & ready_o;
   assign pop       = valid_r & ready_i;
   assign out_free  = ~valid_r | pop;
   // Entries in the array are the total count minus the one held in the output register.
   assign arr_empty = (count_r == {{(count_w-1){1'b0}}, valid_r});

   always_comb begin
      head_n  = head_r;
      tail_n  = tail_r;
      count_n = count_r;
      valid_n = valid_r;
      data_n  = data_r;
      wr_en   = 1'b0;

      if (flush_i) begin
         head_n  = '0;
         tail_n  = '0;
         count_n = '0;
         valid_n = 1'b0;
      end else begin
         count_n = count_r + count_w'(push) - count_w'(pop);
         if (out_free) begin
            if (!arr_empty) begin
               data_n  = mem[head_r];
               valid_n = 1'b1;
               head_n  = ptr_inc(head_r);
               wr_en   = push;
            end else if (push) begin
               data_n  = data_i;
               valid_n = 1'b1;
            end else begin
               valid_n = 1'b0;
            end
         end else begin
            wr_en = push;
         end
         if (wr_en) begin
            tail_n = ptr_inc(tail_r);
         end
      end

      af_n = (count_n >= count_w'(almost_full_p));
      ae_n = (count_n <= count_w'(almost_empty_p));
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
         valid_r <= 1'b0;
         data_r  <= '0;
         af_r    <= 1'b0;
         ae_r    <= 1'b1;
      end else begin
         head_r  <= head_n;
         tail_r  <= tail_n;
         count_r <= count_n;
         valid_r <= valid_n;
         data_r  <= data_n;
         af_r    <= af_n;
         ae_r    <= ae_n;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[tail_r] <= data_i;
      end
   end

   assign valid_o        = valid_r;
   assign data_o         = data_r;
   assign count_o        = count_r;
   assign almost_full_o  = af_r;
   assign almost_empty_o = ae_r;

endmodule

// File: tb/tb_fifo_1r1w_flex.sv
// Scoreboard bench for fifo_1r1w_flex at depth 5, almost_full 4, almost_empty 1.
module tb_fifo_1r1w_flex;

   localparam int unsigned W  = 8;
   localparam int unsigned D  = 5;
   localparam int unsigned AF = 4;
   localparam int unsigned AE = 1;
   localparam int unsigned CW = $clog2(D + 1);

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          flush_i;
   logic [W-1:0]  data_i;
   logic          valid_i;
   logic          ready_o;
   logic          valid_o;
   logic [W-1:0]  data_o;
   logic          ready_i;
   logic [CW-1:0] count_o;
   logic          almost_full_o;
   logic          almost_empty_o;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [W-1:0] sb_q[$];

   fifo_1r1w_flex #(
      .width_p(W),
      .depth_p(D),
      .almost_full_p(AF),
      .almost_empty_p(AE)
   ) dut (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .flush_i(flush_i),
      .data_i(data_i),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .valid_o(valid_o),
      .data_o(data_o),
      .ready_i(ready_i),
      .count_o(count_o),
      .almost_full_o(almost_full_o),
      .almost_empty_o(almost_empty_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle (called just after a posedge), check outputs against the model, advance.
   task automatic cycle(input logic vi, input logic [W-1:0] di, input logic ri, input logic fl);
      int unsigned n;
      logic exp_ready;
      logic do_push;
      logic do_pop;
      valid_i = vi;
      data_i  = di;
      ready_i = ri;
      flush_i = fl;
      #1;
      n = sb_q.size();
      exp_ready = !fl && (n < D);
      check("ready",  32'(ready_o), 32'(exp_ready));
      check("count",  32'(count_o), n);
      check("valid",  32'(valid_o), 32'(n != 0));
      check("afull",  32'(almost_full_o),  32'(n >= AF));
      check("aempty", 32'(almost_empty_o), 32'(n <= AE));
      if (n != 0) check("data", 32'(data_o), 32'(sb_q[0]));
      do_push = vi && exp_ready;
      do_pop  = (n != 0) && ri;
      if (fl) begin
         sb_q.delete();
      end else begin
         if (do_pop)  void'(sb_q.pop_front());
         if (do_push) sb_q.push_back(di);
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * D; i++) cycle(1'b0, '0, 1'b1, 1'b0);
      check("drain_count", 32'(count_o), 0);
   endtask

   initial begin
      int unsigned pushed;
      int unsigned budget;
      logic vi;
      logic ri;
      logic [W-1:0] di;

      reset_i = 1'b1;
      flush_i = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b0;
      data_i  = '0;
      #12;
      check("rst_valid",  32'(valid_o), 0);
      check("rst_data",   32'(data_o), 0);
      check("rst_count",  32'(count_o), 0);
      check("rst_ready",  32'(ready_o), 0);
      check("rst_afull",  32'(almost_full_o), 0);
      check("rst_aempty", 32'(almost_empty_o), 1);
      @(posedge clk_i);
      #1 reset_i = 1'b0;

      // Asynchronous reset while holding three entries
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      check("pre_rst_count", 32'(count_o), 3);
      valid_i = 1'b0;
      #2 reset_i = 1'b1;
      #1;
      check("mid_rst_valid", 32'(valid_o), 0);
      check("mid_rst_count", 32'(count_o), 0);
      check("mid_rst_ready", 32'(ready_o), 0);
      sb_q.delete();
      @(posedge clk_i);
      #1 reset_i = 1'b0;
      #1;
      check("post_rst_ready", 32'(ready_o), 1);
      @(posedge clk_i);
      #1;

      // Fill and drain
      for (int i = 0; i < D; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      check("fill_count", 32'(count_o), D);
      check("fill_ready", 32'(ready_o), 0);
      check("fill_afull", 32'(almost_full_o), 1);
      drain();

      // Streaming through pointer wrap
      for (int i = 0; i < 32; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
      check("stream_count", 32'(count_o), 1);
      drain();

      // Random back-pressure
      pushed = 0;
      budget = 0;
      while (pushed < 1000 && budget < 20000) begin
         vi = 1'($urandom_range(0, 1));
         ri = 1'($urandom_range(0, 1));
         di = 8'($urandom);
         if (vi && sb_q.size() < D) pushed++;
         cycle(vi, di, ri, 1'b0);
         budget++;
      end
      check("rand_items", pushed, 1000);
      drain();

      // Flush with valid and ready both high
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      cycle(1'b1, 8'h55, 1'b1, 1'b1);
      check("flush_count", 32'(count_o), 0);
      check("flush_valid", 32'(valid_o), 0);
      cycle(1'b1, 8'hAA, 1'b0, 1'b0);
      check("flush_first", 32'(data_o), 32'h0AA);
      drain();

      // Full with simultaneous pop: push refused, pop taken
      for (int i = 0; i < D; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      cycle(1'b1, 8'h99, 1'b1, 1'b0);
      check("fullpop_count", 32'(count_o), D - 1);
      check("fullpop_ready", 32'(ready_o), 1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
